// File: rtl/mycpu_sys_pkg.sv
// Shared types and constants for the myCPU system controller: sequencer states,
// default halt mailbox / timeout, and the loader header format.
package mycpu_sys_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN_H = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [15:0] DEFAULT_HALT_ADDR = 16'hFFFF;
    localparam logic [31:0] DEFAULT_TIMEOUT   = 32'd1000000;

    // Loader header: 16-bit program length sent low byte first, then the program bytes.
    localparam int HDR_BYTE_W = 8;
    localparam int HDR_LEN_W  = 2 * HDR_BYTE_W;

    typedef logic [HDR_LEN_W-1:0] len_t;

    function automatic logic is_loader_state(input state_e s);
        case (s)
            IDLE, LEN_H, LOAD, DONE: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mycpu_run_timer.sv
// RUN-phase cycle counter with terminal compare; hit flags the last allowed cycle.
module mycpu_run_timer
    import mycpu_sys_pkg::*;
#(
    parameter logic [31:0] LIMIT = DEFAULT_TIMEOUT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic hit
);

    logic [31:0] cnt_r;

    // Counter: cleared on reset and on RUN entry, advances every RUN cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r <= 32'd0;
        end else if (clr) begin
            cnt_r <= 32'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

    // Terminal compare; a zero limit means no timeout at all
    always_comb begin
        if (LIMIT != 32'd0) begin
            hit = en && (cnt_r == (LIMIT - 32'd1));
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/mycpu_boot_ctrl.sv
// myCPU system controller: loads a length-prefixed program into RAM with the core
// held in reset, then runs the core until a halt-mailbox write or a cycle timeout.
module mycpu_boot_ctrl
    import mycpu_sys_pkg::*;
#(
    parameter logic [15:0] HALT_ADDR      = DEFAULT_HALT_ADDR,
    parameter logic [31:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        cpu_reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_rw,
    output logic [7:0]  cpu_di,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        running,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  exit_code
);

    state_e      state_r;
    len_t        len_r;
    logic [15:0] load_addr_r;

    logic accept_s;
    logic load_wr_s;
    logic halt_s;
    logic run_entry_s;
    logic tmo_hit_s;
    logic run_en_s;

    // Handshake and sequencing decodes
    always_comb begin
        in_ready    = !RESET && is_loader_state(state_r);
        accept_s    = in_valid && in_ready;
        load_wr_s   = (state_r == LOAD) && accept_s;
        run_en_s    = (state_r == RUN);
        halt_s      = run_en_s && cpu_rw && (cpu_ab == HALT_ADDR);
        // A zero-length header skips LOAD entirely instead of meaning 65536 bytes
        run_entry_s = accept_s &&
                      (((state_r == LEN_H) && ({in_data, len_r[HDR_BYTE_W-1:0]} == 16'd0)) ||
                       ((state_r == LOAD)  && (len_r == 16'd1)));
    end

    mycpu_run_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_run_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (run_en_s),
        .clr   (run_entry_s),
        .hit   (tmo_hit_s)
    );

    // Memory port mux: loader owns it only on a LOAD handshake cycle
    always_comb begin
        if (load_wr_s) begin
            mem_addr  = load_addr_r;
            mem_wdata = in_data;
            mem_we    = 1'b1;
        end else begin
            mem_addr  = cpu_ab;
            mem_wdata = cpu_do;
            mem_we    = running && cpu_rw && (cpu_ab != HALT_ADDR);
        end
    end

    assign cpu_di = mem_rdata;

    // Sequencer: header parse, program load, run supervision and result capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= 8'h00;
            load_addr_r <= 16'h0000;
            len_r       <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        len_r[HDR_BYTE_W-1:0] <= in_data;
                        state_r               <= LEN_H;
                    end
                end
                LEN_H: begin
                    if (accept_s) begin
                        len_r[HDR_LEN_W-1:HDR_BYTE_W] <= in_data;
                        load_addr_r                   <= 16'h0000;
                        if (run_entry_s) begin
                            state_r   <= RUN;
                            cpu_reset <= 1'b0;
                            running   <= 1'b1;
                        end else begin
                            state_r <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        load_addr_r <= load_addr_r + 16'd1;
                        len_r       <= len_r - 16'd1;
                        if (run_entry_s) begin
                            state_r   <= RUN;
                            cpu_reset <= 1'b0;
                            running   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Halt takes priority over a timeout landing in the same cycle
                    if (halt_s) begin
                        exit_code <= cpu_do;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                        running   <= 1'b0;
                        state_r   <= DONE;
                    end else if (tmo_hit_s) begin
                        timeout   <= 1'b1;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                        running   <= 1'b0;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    if (accept_s) begin
                        len_r[HDR_BYTE_W-1:0] <= in_data;
                        done                  <= 1'b0;
                        timeout               <= 1'b0;
                        state_r               <= LEN_H;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cpu_reset <= 1'b1;
                    running   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mycpu_boot_ctrl.sv
// Directed bench for mycpu_boot_ctrl: RAM model, bus-level core stand-in and a
// write scoreboard that predicts every RAM write before the DUT issues it.
module tb_mycpu_boot_ctrl;

    localparam logic [15:0] HALT = 16'hFFFF;
    localparam logic [31:0] TMO  = 32'd16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cpu_reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_rw;
    logic [7:0]  cpu_di;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        running;
    logic        done;
    logic        timeout;
    logic [7:0]  exit_code;

    logic [7:0]  ram [0:65535];
    logic [23:0] wr_q [$];
    logic [7:0]  prog_q [$];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 CLK = ~CLK;

    mycpu_boot_ctrl #(
        .HALT_ADDR      (HALT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cpu_reset (cpu_reset),
        .cpu_ab    (cpu_ab),
        .cpu_do    (cpu_do),
        .cpu_rw    (cpu_rw),
        .cpu_di    (cpu_di),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .running   (running),
        .done      (done),
        .timeout   (timeout),
        .exit_code (exit_code)
    );

    assign mem_rdata = ram[mem_addr];

    always @(posedge CLK) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Every RAM write must match the oldest predicted write
    always @(negedge CLK) begin
        logic [23:0] exp_w;
        if (mem_we === 1'b1) begin
            if (wr_q.size() != 0) exp_w = wr_q.pop_front();
            else                  exp_w = 24'hxxxxxx;
            check("mem_write", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_w});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one byte after a random idle gap; returns cpu_reset seen in the handshake cycle
    task automatic send_byte(input logic [7:0] b, input logic wr, input logic [15:0] addr,
                             output logic rst_seen);
        int n;
        repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_data  = b;
        if (wr) wr_q.push_back({addr, b});
        n = 0;
        @(negedge CLK);
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            @(negedge CLK);
            n++;
        end
        check("byte_accepted", 32'(in_ready), 32'd1);
        rst_seen = cpu_reset;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_prog(input logic [15:0] len);
        logic rs;
        send_byte(len[7:0], 1'b0, 16'h0000, rs);
        check("hdr_clears_done", 32'(done), 32'd0);
        check("hdr_clears_timeout", 32'(timeout), 32'd0);
        send_byte(len[15:8], 1'b0, 16'h0000, rs);
        for (int i = 0; i < prog_q.size(); i++) send_byte(prog_q[i], 1'b1, i[15:0], rs);
        check("cpu_reset_in_last_accept", 32'(rs), 32'd1);
        check("cpu_reset_released", 32'(cpu_reset), 32'd0);
        check("running_after_load", 32'(running), 32'd1);
    endtask

    // Core stand-in that only reads, walking addresses from 0, until done
    task automatic run_idle(output int ncyc);
        int it;
        ncyc   = 0;
        it     = 0;
        cpu_rw = 1'b0;
        while (done !== 1'b1 && it < 40) begin
            cpu_ab = 16'(ncyc);
            @(negedge CLK);
            if (running === 1'b1) begin
                if (ncyc < prog_q.size()) check("run_fetch", 32'(cpu_di), 32'(prog_q[ncyc]));
                ncyc++;
            end
            tick();
            it++;
        end
    endtask

    initial begin
        int   ncyc;
        logic rs;
        RESET    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        cpu_ab   = 16'h0000;
        cpu_do   = 8'h00;
        cpu_rw   = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i[15:0]] <= 8'h00;
        ram[HALT] <= 8'h5A;

        // Reset state
        repeat (2) tick();
        @(negedge CLK);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_exit_code", 32'(exit_code), 32'd0);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check("idle_ready", 32'(in_ready), 32'd1);
        tick();

        // 3-byte load with random gaps, then run into the 16-cycle timeout
        prog_q = '{8'hA0, 8'h55, 8'h11};
        load_prog(16'd3);
        check("ram0", 32'(ram[0]), 32'h0A0);
        check("ram1", 32'(ram[1]), 32'h055);
        check("ram2", 32'(ram[2]), 32'h011);
        run_idle(ncyc);
        check("timeout_run_cycles", 32'(ncyc), 32'd16);
        check("timeout_flag", 32'(timeout), 32'd1);
        check("timeout_done", 32'(done), 32'd1);
        check("timeout_exit_code", 32'(exit_code), 32'd0);
        check("timeout_cpu_reset", 32'(cpu_reset), 32'd1);
        check("done_ready", 32'(in_ready), 32'd1);

        // Reload from DONE; core fetches two bytes then writes the halt mailbox
        prog_q = '{8'h12, 8'h2A};
        load_prog(16'd2);
        cpu_ab = 16'h0000;
        @(negedge CLK);
        check("halt_fetch0", 32'(cpu_di), 32'h012);
        check("run_not_ready", 32'(in_ready), 32'd0);
        tick();
        cpu_ab = 16'h0001;
        @(negedge CLK);
        check("halt_fetch1", 32'(cpu_di), 32'h02A);
        tick();
        cpu_ab = HALT;
        cpu_do = 8'h2A;
        cpu_rw = 1'b1;
        @(negedge CLK);
        check("halt_no_we", 32'(mem_we), 32'd0);
        check("halt_done_pre", 32'(done), 32'd0);
        tick();
        cpu_rw = 1'b0;
        check("halt_done", 32'(done), 32'd1);
        check("halt_exit_code", 32'(exit_code), 32'h02A);
        check("halt_timeout", 32'(timeout), 32'd0);
        check("halt_cpu_reset", 32'(cpu_reset), 32'd1);
        check("halt_running", 32'(running), 32'd0);
        check("halt_ram_untouched", 32'(ram[HALT]), 32'h05A);

        // Zero-length header: straight to RUN on preloaded RAM; halt collides with timeout
        prog_q.delete();
        load_prog(16'd0);
        cpu_ab = 16'h0000;
        @(negedge CLK);
        check("zero_len_fetch", 32'(cpu_di), 32'h012);
        tick();
        cpu_ab = 16'h0200;
        cpu_do = 8'h99;
        cpu_rw = 1'b1;
        wr_q.push_back({16'h0200, 8'h99});
        @(negedge CLK);
        check("core_we", 32'(mem_we), 32'd1);
        tick();
        cpu_rw = 1'b0;
        repeat (13) tick();
        cpu_ab = HALT;
        cpu_do = 8'h3C;
        cpu_rw = 1'b1;
        tick();
        cpu_rw = 1'b0;
        check("collide_done", 32'(done), 32'd1);
        check("collide_timeout", 32'(timeout), 32'd0);
        check("collide_exit_code", 32'(exit_code), 32'h03C);
        check("core_write_ram", 32'(ram[16'h0200]), 32'h099);

        // Reset after 2 of 5 program bytes, then reload from IDLE and again from DONE
        send_byte(8'h05, 1'b0, 16'h0000, rs);
        send_byte(8'h00, 1'b0, 16'h0000, rs);
        send_byte(8'hB1, 1'b1, 16'h0000, rs);
        send_byte(8'hB2, 1'b1, 16'h0001, rs);
        RESET = 1'b1;
        @(negedge CLK);
        check("reset_blocks_ready", 32'(in_ready), 32'd0);
        tick();
        @(negedge CLK);
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort_running", 32'(running), 32'd0);
        check("abort_exit_code", 32'(exit_code), 32'd0);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_idle_ready", 32'(in_ready), 32'd1);
        check("abort_ram0", 32'(ram[0]), 32'h0B1);
        check("abort_ram1", 32'(ram[1]), 32'h0B2);
        check("abort_ram2_kept", 32'(ram[2]), 32'h011);
        tick();
        prog_q = '{8'h07};
        load_prog(16'd1);
        check("reload_ram0", 32'(ram[0]), 32'h007);
        run_idle(ncyc);
        check("reload_timeout_cycles", 32'(ncyc), 32'd16);
        check("reload_timeout", 32'(timeout), 32'd1);
        prog_q = '{8'h08};
        load_prog(16'd1);
        check("done_reload_ram0", 32'(ram[0]), 32'h008);

        check("all_writes_seen", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
